axis_rr_arbiter: RTL and testbench

- N-to-1 AXI4-Stream arbiter/multiplexer that shares one downstream stream link between N upstream requesters.
- Packet-locked round-robin: once a port is granted, it keeps the link until its TLAST beat is accepted.
- Sits in front of a single stream slave, e.g. the slave VIP in benches or a shared DMA/FIFO sink in RTL.
- Forwards the granted port's index on TID so the sink can demultiplex.

---
 rtl/axis_rr_arbiter_pkg.sv | 42 ++++
 rtl/axis_skid_buffer.sv | 70 +++++++
 rtl/axis_rr_arbiter.sv | 143 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Package for axis_rr_arbiter.
//   arb_state_t : arbiter FSM states (IDLE = arbitrate, LOCK = packet in flight)
//   rr_pick_t   : round-robin pick result (valid + winner index)
//   rr_pick()   : first asserted request strictly after ptr, wrapping modulo n
package axis_rr_arbiter_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

    localparam int unsigned MAX_PORTS = 16;
    localparam int unsigned MAX_IW    = 4;

    typedef struct packed {
        logic              valid;
        logic [MAX_IW-1:0] idx;
    } rr_pick_t;

    // Walks ptr+1, ptr+2, ... (mod n) and returns the first asserted request.
    // The index is advanced with a compare-and-wrap rather than a modulo so no
    // divider is built for non-power-of-two n.
    function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] req,
                                         input logic [MAX_IW-1:0]    ptr,
                                         input int unsigned          n);
        rr_pick_t    res;
        int unsigned cur;
        res = '0;
        cur = 32'(ptr);
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (i < n) begin
                cur = (cur >= n - 32'd1) ? 32'd0 : cur + 32'd1;
                if (!res.valid && req[cur[MAX_IW-1:0]]) begin
                    res.valid = 1'b1;
                    res.idx   = cur[MAX_IW-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry full-throughput skid register for a valid/ready stream.
// The output stage and the skid stage are both flops; in_ready is simply
// "skid stage empty", so no combinational path runs from out_ready to in_ready.
// Ports:
//   aclk, areset          clock, asynchronous active-high reset (clears both entries)
//   in_valid/in_ready     upstream handshake
//   in_data  [W]          upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data [W]          downstream payload (registered)
module axis_skid_buffer #(
    parameter int unsigned W = 8
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         out_valid_q, out_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [W-1:0] skid_data_q, skid_data_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (out_ready || !out_valid_q) begin
            // Output slot frees up: refill from skid first to keep ordering.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_valid;
                if (in_valid) begin
                    out_data_d = in_data;
                end
            end
        end else if (in_valid && !skid_valid_q) begin
            // Output stalled: park the accepted beat in the skid slot.
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI4-Stream packet-locked round-robin arbiter.
// A port is picked in one IDLE cycle (search starts after the last winner),
// then owns the downstream link until its TLAST beat is accepted.
// Build option: AXIS_RR_ARBITER_OREG_EN inserts a 2-entry skid register on
// the m_* side (registered outputs, +1 cycle latency, 1 beat/cycle).
// Ports:
//   aclk, areset               clock, asynchronous active-high reset
//   s_tvalid/s_tready [N]      per-port handshake
//   s_tdata [N*DW]             per-port data, port i at [i*DW +: DW]
//   s_tlast [N]                per-port end of packet
//   m_tvalid/m_tready          downstream handshake
//   m_tdata [DW], m_tlast      downstream beat
//   m_tid [IW]                 index of the port the beat came from
//   busy                       high while a packet is locked
module axis_rr_arbiter
    import axis_rr_arbiter_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic [N-1:0]    s_tvalid,
    output logic [N-1:0]    s_tready,
    input  logic [N*DW-1:0] s_tdata,
    input  logic [N-1:0]    s_tlast,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tlast,
    output logic [IW-1:0]   m_tid,
    output logic            busy
);

    arb_state_t           state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        grant_q, grant_d;
    logic [MAX_PORTS-1:0] req_pad;
    logic [MAX_IW-1:0]    ptr_pad;
    rr_pick_t             pick;
    logic                 lock;
    logic                 g_valid;
    logic                 g_last;
    logic [DW-1:0]        g_data;
    logic                 in_ready;
    logic                 acc;
    logic                 unused_pick;

    assign lock = (state_q == LOCK);

    always_comb begin
        req_pad            = '0;
        req_pad[N-1:0]     = s_tvalid;
        ptr_pad            = '0;
        ptr_pad[IW-1:0]    = ptr_q;
        pick               = rr_pick(req_pad, ptr_pad, N);
    end

    assign unused_pick = ^pick.idx;

    // Only the granted port's lanes are ever selected onto the shared path.
    assign g_valid = s_tvalid[grant_q];
    assign g_last  = s_tlast[grant_q];
    assign g_data  = s_tdata[grant_q*DW +: DW];

`ifdef AXIS_RR_ARBITER_OREG_EN
    localparam int unsigned PW = DW + 1 + IW;

    logic [PW-1:0] skid_in;
    logic [PW-1:0] skid_out;

    assign skid_in = {g_last, grant_q, g_data};

    axis_skid_buffer #(
        .W (PW)
    ) u_skid (
        .aclk      (aclk),
        .areset    (areset),
        .in_valid  (lock && g_valid),
        .in_ready  (in_ready),
        .in_data   (skid_in),
        .out_valid (m_tvalid),
        .out_ready (m_tready),
        .out_data  (skid_out)
    );

    assign {m_tlast, m_tid, m_tdata} = skid_out;
`else
    assign in_ready = m_tready;
    assign m_tvalid = lock && g_valid;
    assign m_tdata  = lock ? g_data : '0;
    assign m_tlast  = lock && g_last;
    assign m_tid    = lock ? grant_q : '0;
`endif

    // Beat accepted from the granted port (s-side handshake).
    assign acc = lock && g_valid && in_ready;

    always_comb begin
        s_tready = '0;
        if (lock) begin
            s_tready[grant_q] = in_ready;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        unique case (state_q)
            IDLE: begin
                if (pick.valid) begin
                    grant_d = pick.idx[IW-1:0];
                    state_d = LOCK;
                end
            end
            LOCK: begin
                // Winner drops to lowest priority for the next arbitration.
                if (acc && g_last) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(N - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign busy = lock;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic          aclk = 1'b0;
    logic          areset = 1'b1;
    logic [N-1:0]  s_tvalid, s_tready, s_tlast;
    logic [N*DW-1:0] s_tdata;
    logic          m_tvalid, m_tlast, busy;
    logic          m_tready = 1'b0;
    logic [DW-1:0] m_tdata;
    logic [1:0]    m_tid;

    logic          pv [N];
    logic          pl [N];
    logic [DW-1:0] pd [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]          = pv[i];
            s_tlast[i]           = pl[i];
            s_tdata[i*DW +: DW]  = pd[i];
        end
    end

    axis_rr_arbiter #(
        .N  (N),
        .DW (DW)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tlast  (m_tlast),
        .m_tid    (m_tid),
        .busy     (busy)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, req, req, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard -----------------------
    typedef struct {
        int tid;
        int data;
        int last;
    } beat_t;

    beat_t exp_q[$];
    int    log_tid[$];
    int    log_data[$];
    int    log_last[$];
    int    log_cyc[$];

    bit    md_locked = 1'b0;
    int    md_ptr    = N - 1;
    int    md_grant  = 0;
    int    md_cnt    = 0;
    bit    md_rdy, md_acc, md_found, md_mv, md_pop;
    logic [N-1:0] md_exp_rdy;
    beat_t md_nb;

    // Packet-level model: who owns the link, and which beats leave the sources.
    always @(negedge aclk) begin
        if (areset) begin
            md_locked = 1'b0;
            md_ptr    = N - 1;
            md_grant  = 0;
            md_cnt    = 0;
            exp_q.delete();
        end else begin
`ifdef AXIS_RR_ARBITER_OREG_EN
            md_rdy = (md_cnt < 2);
            md_mv  = (md_cnt > 0);
`else
            md_rdy = m_tready;
            md_mv  = md_locked && pv[md_grant];
`endif
            md_exp_rdy = '0;
            if (md_locked && md_rdy) md_exp_rdy[md_grant] = 1'b1;
            check("s_tready", int'(s_tready), int'(md_exp_rdy));
            check("busy", int'(busy), int'(md_locked));
            check("m_tvalid", int'(m_tvalid), int'(md_mv));
            md_acc = md_locked && pv[md_grant] && md_rdy;
            if (md_acc) begin
                md_nb.tid  = md_grant;
                md_nb.data = int'(pd[md_grant]);
                md_nb.last = int'(pl[md_grant]);
                exp_q.push_back(md_nb);
            end
`ifdef AXIS_RR_ARBITER_OREG_EN
            md_pop = (md_cnt > 0) && m_tready;
            md_cnt = md_cnt + int'(md_acc) - int'(md_pop);
`endif
            if (!md_locked) begin
                md_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!md_found && pv[(md_ptr + k) % N]) begin
                        md_found = 1'b1;
                        md_grant = (md_ptr + k) % N;
                    end
                end
                md_locked = md_found;
            end else if (md_acc && pl[md_grant]) begin
                md_ptr    = md_grant;
                md_locked = 1'b0;
            end
        end
    end

    beat_t mon_e;

    // Output monitor: every downstream transfer must match the next expected beat.
    always begin
        @(negedge aclk);
        #2;
        if (!areset && m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got tid=%0d data=0x%0h, expected no beat",
                         m_tid, m_tdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("m_tid", int'(m_tid), mon_e.tid);
                check("m_tdata", int'(m_tdata), mon_e.data);
                check("m_tlast", int'(m_tlast), mon_e.last);
            end
            log_tid.push_back(int'(m_tid));
            log_data.push_back(int'(m_tdata));
            log_last.push_back(int'(m_tlast));
            log_cyc.push_back(cyc);
        end
    end

    // ---------------- downstream ready generator -------------------------
    int rdy_mode = 0;  // 0 always, 1 random, 2 low 2 / high 6
    int osc_ph   = 0;

    always begin
        @(posedge aclk);
        #1;
        case (rdy_mode)
            1:       m_tready = ($urandom_range(9, 0) < 7);
            2: begin
                m_tready = ((osc_ph % 8) >= 2);
                osc_ph++;
            end
            default: m_tready = 1'b1;
        endcase
    end

    // ---------------- stimulus helpers -----------------------------------
    task automatic cyc_wait(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_acc(input int p);
        int n = 0;
        @(negedge aclk);
        while (!s_tready[p] && n < 3000) begin
            n++;
            @(negedge aclk);
        end
        if (n >= 3000) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: port %0d got no s_tready, expected within 3000 cycles",
                     p);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic send_pkt(input int p, input int len, input logic [7:0] d0,
                            input logic [7:0] step, input int mid_gap);
        for (int b = 0; b < len; b++) begin
            pv[p] = 1'b1;
            pd[p] = d0 + 8'(b) * step;
            pl[p] = (b == len - 1);
            wait_acc(p);
            if (b == 0 && mid_gap > 0 && len > 1) begin
                pv[p] = 1'b0;
                cyc_wait(mid_gap);
            end
        end
        pv[p] = 1'b0;
        pl[p] = 1'b0;
    endtask

    task automatic port_run(input int p, input int start_dly, input int npkt, input int minlen,
                            input int maxlen, input int maxgap, input int mid_gap);
        int len, gap;
        if (start_dly > 0) cyc_wait(start_dly);
        for (int k = 0; k < npkt; k++) begin
            len = $urandom_range(maxlen, minlen);
            send_pkt(p, len, 8'($urandom), 8'($urandom) | 8'h01, mid_gap);
            gap = $urandom_range(maxgap, 0);
            if (gap > 0) cyc_wait(gap);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            cyc_wait(1);
            n++;
        end
        cyc_wait(3);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic clear_log();
        log_tid.delete();
        log_data.delete();
        log_last.delete();
        log_cyc.delete();
    endtask

    // ---------------- test sequence --------------------------------------
    int starts[$];
    int prev_last;
    int cnt0, cnt1;
    logic [7:0] exp3 [3];

    initial begin
        for (int i = 0; i < N; i++) begin
            pv[i] = 1'b0;
            pl[i] = 1'b0;
            pd[i] = '0;
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        #2;
        check("rst_s_tready", int'(s_tready), 0);
        check("rst_m_tvalid", int'(m_tvalid), 0);
        check("rst_m_tdata", int'(m_tdata), 0);
        check("rst_m_tlast", int'(m_tlast), 0);
        check("rst_m_tid", int'(m_tid), 0);
        check("rst_busy", int'(busy), 0);
        @(posedge aclk);
        #1;
        areset = 1'b0;
        cyc_wait(2);

        // All ports request with 2-beat packets: strict rotation from port 0.
        clear_log();
        fork
            port_run(0, 0, 2, 2, 2, 0, 0);
            port_run(1, 0, 2, 2, 2, 0, 0);
            port_run(2, 0, 2, 2, 2, 0, 0);
            port_run(3, 0, 2, 2, 2, 0, 0);
        join
        drain();
        prev_last = 1;
        starts.delete();
        foreach (log_tid[i]) begin
            if (prev_last != 0) starts.push_back(log_tid[i]);
            prev_last = log_last[i];
        end
        check("rr_pkt_count", starts.size(), 8);
        for (int i = 0; i < 5; i++) begin
            if (i < starts.size()) check("rr_order", starts[i], i % N);
        end

        // Port 2 alone, fixed 3-beat packet.
        clear_log();
        send_pkt(2, 3, 8'h11, 8'h11, 0);
        drain();
        exp3[0] = 8'h11;
        exp3[1] = 8'h22;
        exp3[2] = 8'h33;
        check("p2_beats", log_data.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < log_data.size()) begin
                check("p2_data", log_data[i], int'(exp3[i]));
                check("p2_tid", log_tid[i], 2);
                check("p2_last", log_last[i], (i == 2) ? 1 : 0);
            end
        end

        // Port 1 stalls mid-packet while port 3 waits for the lock.
        clear_log();
        fork
            port_run(1, 0, 1, 3, 3, 0, 5);
            port_run(3, 3, 1, 2, 2, 0, 0);
        join
        drain();
        check("stall_beats", log_tid.size(), 5);
        if (log_tid.size() == 5) begin
            check("stall_tid0", log_tid[0], 1);
            check("stall_tid2", log_tid[2], 1);
            check("stall_tid3", log_tid[3], 3);
            check("stall_gap", log_cyc[1] - log_cyc[0], 6);
        end

        // Oscillating downstream ready, two ports with 8 beats each.
        clear_log();
        osc_ph   = 0;
        rdy_mode = 2;
        fork
            port_run(0, 0, 2, 4, 4, 0, 0);
            port_run(1, 0, 2, 4, 4, 0, 0);
        join
        drain();
        rdy_mode = 0;
        cnt0 = 0;
        cnt1 = 0;
        foreach (log_tid[i]) begin
            if (log_tid[i] == 0) cnt0++;
            if (log_tid[i] == 1) cnt1++;
        end
        check("osc_port0_beats", cnt0, 8);
        check("osc_port1_beats", cnt1, 8);

        // Random traffic against random backpressure.
        rdy_mode = 1;
        fork
            port_run(0, 0, 6, 1, 4, 3, 0);
            port_run(1, 1, 6, 1, 4, 3, 0);
            port_run(2, 0, 6, 1, 4, 3, 0);
            port_run(3, 2, 6, 1, 4, 3, 0);
        join
        rdy_mode = 0;
        drain();

        // Back-to-back beats with ready high: one beat per cycle.
        clear_log();
        send_pkt(2, 6, 8'h40, 8'h01, 0);
        drain();
        check("thru_beats", log_cyc.size(), 6);
        for (int i = 1; i < 6; i++) begin
            if (i < log_cyc.size()) check("thru_spacing", log_cyc[i] - log_cyc[i-1], 1);
        end

        // Reset in the middle of a packet, then a lone requester on port 3.
        clear_log();
        pv[0] = 1'b1;
        pd[0] = 8'hA0;
        pl[0] = 1'b0;
        wait_acc(0);
        pd[0] = 8'hA1;
        @(negedge aclk);
        #3;
        areset = 1'b1;
        @(negedge aclk);
        #2;
        check("mid_rst_m_tvalid", int'(m_tvalid), 0);
        check("mid_rst_s_tready", int'(s_tready), 0);
        check("mid_rst_busy", int'(busy), 0);
        pv[0] = 1'b0;
        pv[3] = 1'b1;
        pd[3] = 8'h5A;
        pl[3] = 1'b1;
        @(posedge aclk);
        #1;
        areset = 1'b0;
        @(posedge aclk);
        @(negedge aclk);
        #2;
        check("post_rst_busy", int'(busy), 1);
        check("post_rst_s_tready", int'(s_tready), 8);
        @(posedge aclk);
        #1;
        pv[3] = 1'b0;
        pl[3] = 1'b0;
        drain();
        check("post_rst_beats_nonzero", int'(log_tid.size() > 0), 1);
        if (log_tid.size() > 0) begin
            check("post_rst_tid", log_tid[log_tid.size()-1], 3);
            check("post_rst_data", log_data[log_data.size()-1], 8'h5A);
            check("post_rst_last", log_last[log_last.size()-1], 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
